mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 36 +++
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_responder_resp_pipe.sv | 39 +++
 rtl/mem_responder.sv | 145 ++++++++++++++
 tb/tb_mem_responder.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared memory-protocol definitions for the cache-to-memory interface.
// Holds bus widths, command encodings, the responder mode enum, the held
// write-beat struct and a byte-merge helper.
package mem_responder_pkg;

    localparam int   MEM_DATA_BITS = 128;
    localparam int   MEM_ADDR_BITS = 28;
    localparam int   MEM_MASK_BITS = 16;
    localparam logic MEM_READ      = 1'b0;
    localparam logic MEM_WRITE     = 1'b1;

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_WCMD,
        MODE_WDATA
    } mode_e;

    typedef struct packed {
        logic [MEM_DATA_BITS-1:0] data;
        logic [MEM_MASK_BITS-1:0] mask;
    } mem_beat_t;

    // Replace the bytes of old_line whose mask bit is set.
    function automatic logic [MEM_DATA_BITS-1:0] merge_bytes(
        input logic [MEM_DATA_BITS-1:0] old_line,
        input mem_beat_t                beat
    );
        logic [MEM_DATA_BITS-1:0] res;
        res = old_line;
        for (int i = 0; i < MEM_MASK_BITS; i++) begin
            if (beat.mask[i]) res[8*i +: 8] = beat.data[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Cache-to-memory request/response bus.
//   master : cache side (drives commands and write beats)
//   slave  : memory side (drives readies and read responses)
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic [MEM_ADDR_BITS-1:0] mem_req_addr;
    logic                     mem_req_rw;
    logic                     mem_req_data_valid;
    logic                     mem_req_data_ready;
    logic [MEM_DATA_BITS-1:0] mem_req_data_bits;
    logic [MEM_MASK_BITS-1:0] mem_req_data_mask;
    logic                     mem_resp_valid;
    logic [MEM_DATA_BITS-1:0] mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_rw,
               mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_rw,
               mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/mem_responder_resp_pipe.sv
// mem_resp_pipe: LATENCY-deep valid/data shift register, async clear.
// Data stages carry zero whenever their valid bit is low, so the output
// data is 0 outside a valid pulse.
//   clk, rst           : clock, async active-high clear
//   in_valid, in_data  : stage input
//   out_valid, out_data: last stage
module mem_resp_pipe #(
    parameter int LATENCY = 4,
    parameter int WIDTH   = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LATENCY-1:0]            vld_pipe_q;
    logic [LATENCY-1:0][WIDTH-1:0] data_pipe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q  <= '0;
            data_pipe_q <= '0;
        end else begin
            vld_pipe_q[0]  <= in_valid;
            data_pipe_q[0] <= in_valid ? in_data : '0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
                data_pipe_q[i] <= data_pipe_q[i-1];
            end
        end
    end

    assign out_valid = vld_pipe_q[LATENCY-1];
    assign out_data  = data_pipe_q[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: synthesizable main-memory model below the caches.
// Pairs write commands with masked write beats (either order or same
// cycle), stores lines in an internal array and returns read data in
// order LATENCY cycles after acceptance.
//   clk, reset : clock, async active-high reset
//   bus        : mem_responder_if.slave (request, write-data, response)
// Optional build macro MEM_RESPONDER_STALL_EN adds an LFSR that randomly
// drops both readies to create wait states.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_LINES = 4096,
    parameter int LATENCY     = 4
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int IDX_BITS = $clog2(DEPTH_LINES);

    logic [MEM_DATA_BITS-1:0] mem_q [DEPTH_LINES];

    mode_e                    mode_q, mode_d;
    logic                     req_ready_q, data_ready_q;
    logic [IDX_BITS-1:0]      pend_idx_q, pend_idx_d;
    mem_beat_t                pend_beat_q, pend_beat_d;
    logic                     rd_vld_q;
    logic [MEM_DATA_BITS-1:0] rd_data_q;

    logic                     cmd_acc, beat_acc, wr_cmd, rd_cmd, wr_en, stall_d;
    logic [IDX_BITS-1:0]      cmd_idx, wr_idx;
    mem_beat_t                in_beat, wr_beat;
    logic [MEM_DATA_BITS-1:0] rd_line;
    logic [MEM_ADDR_BITS-1:0] unused_addr;

    assign cmd_acc     = bus.mem_req_valid & req_ready_q;
    assign beat_acc    = bus.mem_req_data_valid & data_ready_q;
    assign wr_cmd      = cmd_acc & (bus.mem_req_rw == MEM_WRITE);
    assign rd_cmd      = cmd_acc & (bus.mem_req_rw == MEM_READ);
    assign cmd_idx     = bus.mem_req_addr[IDX_BITS-1:0];
    assign unused_addr = bus.mem_req_addr;  // upper bits alias by design
    assign in_beat     = '{data: bus.mem_req_data_bits, mask: bus.mem_req_data_mask};

    // Pairing decode: the write commits in the cycle its pair completes.
    always_comb begin
        mode_d      = mode_q;
        pend_idx_d  = pend_idx_q;
        pend_beat_d = pend_beat_q;
        wr_en       = 1'b0;
        wr_idx      = cmd_idx;
        wr_beat     = in_beat;
        case (mode_q)
            MODE_IDLE: begin
                if (wr_cmd && beat_acc) begin
                    wr_en = 1'b1;
                end else if (wr_cmd) begin
                    mode_d     = MODE_WCMD;
                    pend_idx_d = cmd_idx;
                end else if (beat_acc) begin
                    mode_d      = MODE_WDATA;
                    pend_beat_d = in_beat;
                end
            end
            MODE_WCMD: begin
                if (beat_acc) begin
                    wr_en  = 1'b1;
                    wr_idx = pend_idx_q;
                    mode_d = MODE_IDLE;
                end
            end
            MODE_WDATA: begin
                // A read here proceeds and leaves the held beat alone.
                if (wr_cmd) begin
                    wr_en   = 1'b1;
                    wr_beat = pend_beat_q;
                    mode_d  = MODE_IDLE;
                end
            end
            default: mode_d = MODE_IDLE;
        endcase
    end

`ifdef MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    // Readies are registered, so stall on the LFSR value of the next cycle.
    assign stall_d = lfsr_d[0];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign stall_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q       <= MODE_IDLE;
            req_ready_q  <= 1'b0;
            data_ready_q <= 1'b0;
            pend_idx_q   <= '0;
            pend_beat_q  <= '0;
        end else begin
            mode_q       <= mode_d;
            req_ready_q  <= (mode_d != MODE_WCMD) & ~stall_d;
            data_ready_q <= (mode_d != MODE_WDATA) & ~stall_d;
            pend_idx_q   <= pend_idx_d;
            pend_beat_q  <= pend_beat_d;
        end
    end

    // Array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= merge_bytes(mem_q[wr_idx], wr_beat);
    end

    // Write-first bypass for a same-cycle commit to the read index.
    assign rd_line = (wr_en && (wr_idx == cmd_idx)) ? merge_bytes(mem_q[cmd_idx], wr_beat)
                                                   : mem_q[cmd_idx];

    // Sample stage at acceptance; the pipe adds the remaining LATENCY edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q  <= rd_cmd;
            rd_data_q <= rd_cmd ? rd_line : '0;
        end
    end

    mem_resp_pipe #(.LATENCY(LATENCY), .WIDTH(MEM_DATA_BITS)) u_pipe (
        .clk      (clk),
        .rst      (reset),
        .in_valid (rd_vld_q),
        .in_data  (rd_data_q),
        .out_valid(bus.mem_resp_valid),
        .out_data (bus.mem_resp_data)
    );

    assign bus.mem_req_ready      = req_ready_q;
    assign bus.mem_req_data_ready = data_ready_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int L = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if bus();

    mem_responder #(.DEPTH_LINES(4096), .LATENCY(L)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int stalls = 0;

    typedef struct {
        logic [127:0] d;
        int           c;
    } resp_t;
    resp_t rq[$];

    always @(posedge clk) cyc++;

    // Response monitor: record pulses with their cycle, check idle data is 0.
    always @(negedge clk) begin
        if (bus.mem_resp_valid) begin
            rq.push_back('{bus.mem_resp_data, cyc});
        end else begin
            checks++;
            if (bus.mem_resp_data !== 128'h0) begin
                errors++;
                $display("FAIL idle_data got %h exp 0", bus.mem_resp_data);
            end
        end
        if (!reset && !bus.mem_req_ready && !bus.mem_req_data_ready) stalls++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a command and/or a beat until each is accepted; tacc = accept cycle.
    task automatic xfer(input bit do_cmd, input bit do_beat, input logic [27:0] a,
                        input logic rw, input logic [127:0] d, input logic [15:0] m,
                        output int tacc);
        bit cdone, ddone, rc, rd;
        int n;
        cdone = !do_cmd;
        ddone = !do_beat;
        n     = 0;
        tacc  = -1;
        if (do_cmd) begin
            bus.mem_req_valid = 1'b1;
            bus.mem_req_addr  = a;
            bus.mem_req_rw    = rw;
        end
        if (do_beat) begin
            bus.mem_req_data_valid = 1'b1;
            bus.mem_req_data_bits  = d;
            bus.mem_req_data_mask  = m;
        end
        while (!(cdone && ddone) && n < 200) begin
            rc = bus.mem_req_ready;
            rd = bus.mem_req_data_ready;
            tick();
            n++;
            if (!cdone && rc) begin
                cdone = 1'b1;
                bus.mem_req_valid = 1'b0;
                tacc = cyc;
            end
            if (!ddone && rd) begin
                ddone = 1'b1;
                bus.mem_req_data_valid = 1'b0;
            end
        end
        if (!(cdone && ddone)) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout got cmd %0d beat %0d exp both accepted", cdone, ddone);
            bus.mem_req_valid      = 1'b0;
            bus.mem_req_data_valid = 1'b0;
        end
    endtask

    task automatic wait_resp(input logic [127:0] exp, input int expc, input string nm);
        int n;
        resp_t r;
        n = 0;
        while (rq.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rq.size() == 0) begin
            errors++;
            $display("FAIL %s_timeout got none exp %h", nm, exp);
        end else begin
            r = rq.pop_front();
            if (r.d !== exp) begin
                errors++;
                $display("FAIL %s_data got %h exp %h", nm, r.d, exp);
            end
            checks++;
            if (r.c !== expc) begin
                errors++;
                $display("FAIL %s_cycle got %0d exp %0d", nm, r.c, expc);
            end
        end
        tick();
    endtask

    task automatic chk_bit(input logic got, input logic exp, input string nm);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", nm, got, exp);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        chk_bit(bus.mem_req_ready,      1'b0, "rst_req_ready");
        chk_bit(bus.mem_req_data_ready, 1'b0, "rst_data_ready");
        chk_bit(bus.mem_resp_valid,     1'b0, "rst_resp_valid");
        checks++;
        if (bus.mem_resp_data !== 128'h0) begin
            errors++;
            $display("FAIL rst_resp_data got %h exp 0", bus.mem_resp_data);
        end
        reset = 1'b0;
        tick();
        chk_bit(bus.mem_req_ready,      1'b1, "post_rst_req_ready");
        chk_bit(bus.mem_req_data_ready, 1'b1, "post_rst_data_ready");
    endtask

    task automatic test_basic();
        int t;
        logic [127:0] d;
        d = 128'h0123456789ABCDEF0123456789ABCDEF;
        xfer(1, 1, 28'h10, MEM_WRITE, d, 16'hFFFF, t);
        xfer(1, 0, 28'h10, MEM_READ, '0, '0, t);
        wait_resp(d, t + L, "basic");
        repeat (3) tick();
        checks++;
        if (rq.size() != 0) begin
            errors++;
            $display("FAIL basic_single_pulse got %0d extra exp 0", rq.size());
        end
    endtask

    task automatic test_partial_mask();
        int t;
        xfer(1, 1, 28'h20, MEM_WRITE, {128{1'b1}}, 16'hFFFF, t);
        xfer(1, 1, 28'h20, MEM_WRITE, 128'h0, 16'h000F, t);
        xfer(1, 0, 28'h20, MEM_READ, '0, '0, t);
        wait_resp({{96{1'b1}}, 32'h0}, t + L, "partial");
    endtask

    task automatic test_split();
        int t;
        logic [127:0] d1, d2;
        d1 = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        d2 = 128'h5A5A_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999;
        // Command first: mem_req_ready low for cycles 1-3.
        xfer(1, 0, 28'h30, MEM_WRITE, '0, '0, t);
        chk_bit(bus.mem_req_ready,      1'b0, "wcmd_ready_c1");
        chk_bit(bus.mem_req_data_ready, 1'b1, "wcmd_dready_c1");
        tick();
        chk_bit(bus.mem_req_ready, 1'b0, "wcmd_ready_c2");
        tick();
        chk_bit(bus.mem_req_ready, 1'b0, "wcmd_ready_c3");
        xfer(0, 1, '0, MEM_WRITE, d1, 16'hFFFF, t);
        chk_bit(bus.mem_req_ready, 1'b1, "wcmd_ready_done");
        xfer(1, 0, 28'h30, MEM_READ, '0, '0, t);
        wait_resp(d1, t + L, "split_cmd_first");
        // Beat first: mem_req_data_ready low for cycles 1-3.
        xfer(0, 1, '0, MEM_WRITE, d2, 16'hFFFF, t);
        chk_bit(bus.mem_req_data_ready, 1'b0, "wdata_dready_c1");
        chk_bit(bus.mem_req_ready,      1'b1, "wdata_ready_c1");
        tick();
        chk_bit(bus.mem_req_data_ready, 1'b0, "wdata_dready_c2");
        tick();
        chk_bit(bus.mem_req_data_ready, 1'b0, "wdata_dready_c3");
        xfer(1, 0, 28'h34, MEM_WRITE, '0, '0, t);
        chk_bit(bus.mem_req_data_ready, 1'b1, "wdata_dready_done");
        xfer(1, 0, 28'h34, MEM_READ, '0, '0, t);
        wait_resp(d2, t + L, "split_beat_first");
    endtask

    task automatic test_stray_beat();
        int t;
        logic [127:0] d;
        d = 128'h0BAD_F00D_0BAD_F00D_0BAD_F00D_0BAD_F00D;
        xfer(0, 1, '0, MEM_WRITE, d, 16'hFFFF, t);
        xfer(1, 0, 28'h10, MEM_READ, '0, '0, t);
        chk_bit(bus.mem_req_data_ready, 1'b0, "stray_beat_held");
        wait_resp(128'h0123456789ABCDEF0123456789ABCDEF, t + L, "stray_read");
        xfer(1, 0, 28'h38, MEM_WRITE, '0, '0, t);
        xfer(1, 0, 28'h38, MEM_READ, '0, '0, t);
        wait_resp(d, t + L, "stray_commit");
        // Upper address bits alias onto the same line.
        xfer(1, 0, 28'hFFF_F038, MEM_READ, '0, '0, t);
        wait_resp(d, t + L, "alias");
    endtask

    task automatic test_back_to_back();
        int t;
        int ta[4];
        for (int i = 0; i < 4; i++) begin
            xfer(1, 1, 28'(i), MEM_WRITE, {4{32'hC0DE_0000 + 32'(i)}}, 16'hFFFF, t);
        end
        for (int i = 0; i < 4; i++) begin
            xfer(1, 0, 28'(i), MEM_READ, '0, '0, ta[i]);
        end
        checks++;
        if (ta[3] - ta[0] != 3) begin
            errors++;
            $display("FAIL b2b_accept_span got %0d exp 3", ta[3] - ta[0]);
        end
        for (int i = 0; i < 4; i++) begin
            resp_t r;
            while (rq.size() == 0 && cyc < ta[0] + L + 12) @(negedge clk);
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL b2b_timeout got none exp read %0d", i);
            end else begin
                r = rq.pop_front();
                if (r.d !== {4{32'hC0DE_0000 + 32'(i)}} || r.c !== ta[0] + L + i) begin
                    errors++;
                    $display("FAIL b2b_resp%0d got %h @%0d exp %h @%0d", i, r.d, r.c,
                             {4{32'hC0DE_0000 + 32'(i)}}, ta[0] + L + i);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int t;
        // Held beat that reset must discard.
        xfer(0, 1, '0, MEM_WRITE, 128'hDEAD, 16'hFFFF, t);
        xfer(1, 0, 28'h10, MEM_READ, '0, '0, t);
        tick();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_bit(bus.mem_req_ready,      1'b0, "midrst_ready");
            chk_bit(bus.mem_req_data_ready, 1'b0, "midrst_dready");
            chk_bit(bus.mem_resp_valid,     1'b0, "midrst_valid");
            tick();
        end
        reset = 1'b0;
        tick();
        chk_bit(bus.mem_req_ready,      1'b1, "midrst_ready_back");
        chk_bit(bus.mem_req_data_ready, 1'b1, "midrst_dready_back");
        repeat (8) tick();
        checks++;
        if (rq.size() != 0) begin
            errors++;
            $display("FAIL midrst_dropped got %0d responses exp 0", rq.size());
            rq.delete();
        end
        xfer(1, 0, 28'h10, MEM_READ, '0, '0, t);
        wait_resp(128'h0123456789ABCDEF0123456789ABCDEF, t + L, "midrst_array_kept");
    endtask

`ifdef MEM_RESPONDER_STALL_EN
    task automatic test_stall();
        logic [127:0] model [16];
        logic [127:0] d;
        logic [15:0]  m;
        int t, a;
        reset = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            xfer(1, 1, 28'h100 + 28'(i), MEM_WRITE, d, 16'hFFFF, t);
            model[i] = d;
        end
        for (int n = 0; n < 100; n++) begin
            a = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                m = 16'($urandom);
                xfer(1, 1, 28'h100 + 28'(a), MEM_WRITE, d, m, t);
                for (int b = 0; b < 16; b++) if (m[b]) model[a][8*b +: 8] = d[8*b +: 8];
            end else begin
                xfer(1, 0, 28'h100 + 28'(a), MEM_READ, '0, '0, t);
                wait_resp(model[a], t + L, "stall_rd");
            end
        end
        checks++;
        if (stalls == 0) begin
            errors++;
            $display("FAIL stall_seen got 0 exp >0");
        end
    endtask
`endif

    initial begin
        bus.mem_req_valid      = 1'b0;
        bus.mem_req_addr       = '0;
        bus.mem_req_rw         = MEM_READ;
        bus.mem_req_data_valid = 1'b0;
        bus.mem_req_data_bits  = '0;
        bus.mem_req_data_mask  = '0;
`ifdef MEM_RESPONDER_STALL_EN
        repeat (2) tick();
        test_stall();
`else
        test_reset();
        test_basic();
        test_partial_mask();
        test_split();
        test_stray_beat();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
